// File: rtl/register_writeback_unit_pkg.sv
// Shared types for the register-file write path: write strobe, load
// funct3 encodings, writeback FSM states and a write-slot record.
package JZJCoreFTypes;

   typedef enum logic {
      WRITE_DISABLE = 1'b0,
      WRITE_ENABLE  = 1'b1
   } WriteEnable_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } LoadFunct3_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } WritebackState_t;

   // One register-file write: destination and data.
   typedef struct packed {
      logic [4:0]  address;
      logic [31:0] data;
   } WritebackEntry_t;

endpackage

// File: rtl/register_writeback_unit_extender.sv
// Load data extractor: picks the addressed byte/half out of the memory word
// and sign- or zero-extends it according to the load funct3.
module load_extender
   import JZJCoreFTypes::*;
(
   input  logic [31:0] i_memRdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_offset,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the lane and apply the extension rule for the load type.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      o_data = i_memRdata;
      w_byte = i_memRdata[8*i_offset +: 8];
      w_half = i_offset[1] ? i_memRdata[31:16] : i_memRdata[15:0];
      case (i_funct3)
         LB:      o_data = {{24{w_byte[7]}}, w_byte};
         LH:      o_data = {{16{w_half[15]}}, w_half};
         LBU:     o_data = {24'd0, w_byte};
         LHU:     o_data = {16'd0, w_half};
         default: o_data = i_memRdata;   // LW and unused encodings
      endcase
   end

endmodule

// File: rtl/register_writeback_unit.sv
// Write-side front end of the register file: accepts ALU results and one
// outstanding load, extends load data, serialises both onto the single
// write port (load first, ALU parked in a one-entry hold buffer) and raises
// a load-use stall for decode.
module register_writeback_unit
   import JZJCoreFTypes::*;
#(
   parameter bit RV32I = 1'b1
)(
   input  logic         clock,
   input  logic         reset,
   input  logic         aluValid,
   output logic         aluReady,
   input  logic [31:0]  aluResult,
   input  logic [4:0]   aluRdAddress,
   input  logic         loadIssue,
   output logic         loadReady,
   input  logic [4:0]   loadRdAddress,
   input  logic [2:0]   loadFunct3,
   input  logic [1:0]   loadByteOffset,
   input  logic [31:0]  memRdata,
   input  logic         memRvalid,
   input  logic [4:0]   rs1Address,
   input  logic [4:0]   rs2Address,
   output logic         loadUseStall,
   output logic [31:0]  rd,
   output logic [4:0]   rdAddress,
   output WriteEnable_t rdWriteEnable,
   output logic         illegalRegister
);

   // RV32E only decodes the low four address bits.
   localparam logic [4:0] ADDRESS_MASK = RV32I ? 5'h1F : 5'h0F;

   WritebackState_t r_state;
   logic [4:0]      r_pendingRd;
   logic [2:0]      r_pendingFunct3;
   logic [1:0]      r_pendingOffset;
   logic            r_holdValid;
   WritebackEntry_t r_holdEntry;

   logic [31:0]     w_loadData;
   logic            w_loadDone;
   logic            w_aluAccept;
   logic            w_writeValid;
   WritebackEntry_t w_writeEntry;
   logic            w_illegal;
   logic [4:0]      w_maskedPending;

   assign aluReady    = ~r_holdValid;
   assign loadReady   = (r_state == IDLE);
   assign w_loadDone  = (r_state == WAIT) && memRvalid;
   assign w_aluAccept = aluValid && aluReady;

   // A pending x0 load never stalls; the write is dropped anyway.
   assign w_maskedPending = r_pendingRd & ADDRESS_MASK;
   assign loadUseStall    = (r_state == WAIT) && (w_maskedPending != 5'd0) &&
                            (((rs1Address & ADDRESS_MASK) == w_maskedPending) ||
                             ((rs2Address & ADDRESS_MASK) == w_maskedPending));

   load_extender u_load_extender (
      .i_memRdata (memRdata),
      .i_funct3   (r_pendingFunct3),
      .i_offset   (r_pendingOffset),
      .o_data     (w_loadData)
   );

   // Pick this cycle's write slot: load, then held ALU result, then fresh ALU.
   always_comb begin
      w_writeValid = 1'b0;
      w_writeEntry = '0;
      if (w_loadDone) begin
         w_writeValid = 1'b1;
         w_writeEntry = '{address: r_pendingRd, data: w_loadData};
      end else if (r_holdValid) begin
         w_writeValid = 1'b1;
         w_writeEntry = r_holdEntry;
      end else if (w_aluAccept) begin
         w_writeValid = 1'b1;
         w_writeEntry = '{address: aluRdAddress, data: aluResult};
      end
      w_illegal = !RV32I && w_writeValid && w_writeEntry.address[4];
   end

   // Load tracking FSM: latch the request in IDLE, wait for memory in WAIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_pendingRd     <= 5'd0;
         r_pendingFunct3 <= 3'd0;
         r_pendingOffset <= 2'd0;
      end else begin
         // NOTE: sequential state uses <= so every register samples pre-edge values.
         case (r_state)
            IDLE: if (loadIssue) begin
               r_pendingRd     <= loadRdAddress;
               r_pendingFunct3 <= loadFunct3;
               r_pendingOffset <= loadByteOffset;
               r_state         <= WAIT;
            end
            WAIT: if (memRvalid) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Park an ALU result that collides with a load; drain it next cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_holdValid <= 1'b0;
         r_holdEntry <= '0;
      end else if (w_loadDone && w_aluAccept) begin
         r_holdValid <= 1'b1;
         r_holdEntry <= '{address: aluRdAddress, data: aluResult};
      end else if (r_holdValid && !w_loadDone) begin
         r_holdValid <= 1'b0;
      end
   end

   // Registered write port with x0 / RV32E filtering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd              <= 32'd0;
         rdAddress       <= 5'd0;
         rdWriteEnable   <= WRITE_DISABLE;
         illegalRegister <= 1'b0;
      end else begin
         illegalRegister <= w_illegal;
         rdWriteEnable   <= (w_writeValid && !w_illegal && (w_writeEntry.address != 5'd0))
                            ? WRITE_ENABLE : WRITE_DISABLE;
         if (w_writeValid) begin
            rd        <= w_writeEntry.data;
            rdAddress <= w_writeEntry.address & ADDRESS_MASK;
         end
      end
   end

endmodule

// File: tb/tb_register_writeback_unit.sv
// Bench for register_writeback_unit: directed scenarios plus a randomized
// run against a write-queue reference model, on an RV32I and an RV32E copy.
module tb_register_writeback_unit;
   import JZJCoreFTypes::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        aluValid, loadIssue, memRvalid;
   logic [31:0] aluResult, memRdata;
   logic [4:0]  aluRdAddress, loadRdAddress, rs1Address, rs2Address;
   logic [2:0]  loadFunct3;
   logic [1:0]  loadByteOffset;

   logic        aluReady_i, loadReady_i, stall_i, we_i, illegal_i;
   logic [31:0] rd_i;
   logic [4:0]  rdAddress_i;
   logic        aluReady_e, loadReady_e, stall_e, we_e, illegal_e;
   logic [31:0] rd_e;
   logic [4:0]  rdAddress_e;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   register_writeback_unit #(.RV32I(1'b1)) dut_i (
      .clock(clock), .reset(reset),
      .aluValid(aluValid), .aluReady(aluReady_i), .aluResult(aluResult), .aluRdAddress(aluRdAddress),
      .loadIssue(loadIssue), .loadReady(loadReady_i), .loadRdAddress(loadRdAddress),
      .loadFunct3(loadFunct3), .loadByteOffset(loadByteOffset),
      .memRdata(memRdata), .memRvalid(memRvalid),
      .rs1Address(rs1Address), .rs2Address(rs2Address), .loadUseStall(stall_i),
      .rd(rd_i), .rdAddress(rdAddress_i), .rdWriteEnable(we_i), .illegalRegister(illegal_i)
   );

   register_writeback_unit #(.RV32I(1'b0)) dut_e (
      .clock(clock), .reset(reset),
      .aluValid(aluValid), .aluReady(aluReady_e), .aluResult(aluResult), .aluRdAddress(aluRdAddress),
      .loadIssue(loadIssue), .loadReady(loadReady_e), .loadRdAddress(loadRdAddress),
      .loadFunct3(loadFunct3), .loadByteOffset(loadByteOffset),
      .memRdata(memRdata), .memRvalid(memRvalid),
      .rs1Address(rs1Address), .rs2Address(rs2Address), .loadUseStall(stall_e),
      .rd(rd_e), .rdAddress(rdAddress_e), .rdWriteEnable(we_e), .illegalRegister(illegal_e)
   );

   // Reference extension computed arithmetically from the load rules.
   function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
      logic [31:0] b;
      logic [31:0] h;
      b = (w >> (8 * int'(off))) & 32'hFF;
      h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return w;
      endcase
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      aluValid = 0; aluResult = 0; aluRdAddress = 0;
      loadIssue = 0; loadRdAddress = 0; loadFunct3 = 0; loadByteOffset = 0;
      memRdata = 0; memRvalid = 0; rs1Address = 0; rs2Address = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 reset = 1'b1;
      step(); step();
      tests++; if (rd_i !== 32'd0)      begin fails++; $display("FAIL reset_rd: got %h want 0", rd_i); end
      tests++; if (rdAddress_i !== 5'd0) begin fails++; $display("FAIL reset_rdAddress: got %0d want 0", rdAddress_i); end
      tests++; if (we_i !== 1'b0)        begin fails++; $display("FAIL reset_we: got %b want 0", we_i); end
      tests++; if (illegal_e !== 1'b0)   begin fails++; $display("FAIL reset_illegal: got %b want 0", illegal_e); end
      reset = 1'b0;
      step();
      tests++; if (aluReady_i !== 1'b1)  begin fails++; $display("FAIL reset_aluReady: got %b want 1", aluReady_i); end
      tests++; if (loadReady_i !== 1'b1 || loadReady_e !== 1'b1) begin fails++; $display("FAIL reset_loadReady: got %b/%b want 1/1", loadReady_i, loadReady_e); end
      tests++; if (stall_i !== 1'b0)     begin fails++; $display("FAIL reset_stall: got %b want 0", stall_i); end
      tests++; if (we_i !== 1'b0 || we_e !== 1'b0) begin fails++; $display("FAIL reset_idle_we: got %b/%b want 0/0", we_i, we_e); end
   endtask

   task automatic test_alu_only();
      aluValid = 1; aluResult = 32'h12345678; aluRdAddress = 5;
      #1;
      tests++; if (aluReady_i !== 1'b1) begin fails++; $display("FAIL alu_ready: got %b want 1", aluReady_i); end
      step(); aluValid = 0;
      tests++; if (we_i !== 1'b1 || rd_i !== 32'h12345678 || rdAddress_i !== 5'd5)
         begin fails++; $display("FAIL alu_write: got we=%b rd=%h addr=%0d want we=1 rd=12345678 addr=5", we_i, rd_i, rdAddress_i); end
      step();
      tests++; if (we_i !== 1'b0 || rd_i !== 32'h12345678)
         begin fails++; $display("FAIL alu_one_cycle: got we=%b rd=%h want we=0 rd=12345678", we_i, rd_i); end
   endtask

   task automatic test_load_extension();
      logic [2:0] f3s [2];
      logic [31:0] exps [2];
      f3s[0] = 3'b000; exps[0] = 32'hFFFFFFFF;
      f3s[1] = 3'b101; exps[1] = 32'h000080FF;
      for (int k = 0; k < 2; k++) begin
         loadIssue = 1; loadFunct3 = f3s[k]; loadByteOffset = 2; loadRdAddress = 7;
         step(); loadIssue = 0;
         #1;
         tests++; if (loadReady_i !== 1'b0) begin fails++; $display("FAIL load_busy_%0d: got loadReady=%b want 0", k, loadReady_i); end
         memRvalid = 1; memRdata = 32'h80FF7F01;
         step(); memRvalid = 0;
         tests++; if (we_i !== 1'b1 || rd_i !== exps[k] || rdAddress_i !== 5'd7)
            begin fails++; $display("FAIL load_ext_%0d: got we=%b rd=%h addr=%0d want we=1 rd=%h addr=7", k, we_i, rd_i, rdAddress_i, exps[k]); end
         tests++; if (loadReady_i !== 1'b1) begin fails++; $display("FAIL load_ready_back_%0d: got %b want 1", k, loadReady_i); end
      end
   endtask

   task automatic test_collision();
      loadIssue = 1; loadFunct3 = 3'b010; loadRdAddress = 3; loadByteOffset = 1;
      step(); loadIssue = 0;
      memRvalid = 1; memRdata = 32'hCAFEF00D;
      aluValid = 1; aluResult = 32'h0BADBEEF; aluRdAddress = 4;
      #1;
      tests++; if (aluReady_i !== 1'b1) begin fails++; $display("FAIL coll_ready_before: got %b want 1", aluReady_i); end
      step(); memRvalid = 0; aluValid = 0;
      #1;
      tests++; if (we_i !== 1'b1 || rdAddress_i !== 5'd3 || rd_i !== 32'hCAFEF00D)
         begin fails++; $display("FAIL coll_first: got we=%b addr=%0d rd=%h want we=1 addr=3 rd=cafef00d", we_i, rdAddress_i, rd_i); end
      tests++; if (aluReady_i !== 1'b0) begin fails++; $display("FAIL coll_ready_held: got %b want 0", aluReady_i); end
      step();
      tests++; if (we_i !== 1'b1 || rdAddress_i !== 5'd4 || rd_i !== 32'h0BADBEEF)
         begin fails++; $display("FAIL coll_second: got we=%b addr=%0d rd=%h want we=1 addr=4 rd=0badbeef", we_i, rdAddress_i, rd_i); end
      tests++; if (aluReady_i !== 1'b1) begin fails++; $display("FAIL coll_ready_after: got %b want 1", aluReady_i); end
      step();
      tests++; if (we_i !== 1'b0) begin fails++; $display("FAIL coll_quiet: got we=%b want 0", we_i); end
   endtask

   task automatic test_load_use();
      rs1Address = 1; rs2Address = 9;
      loadIssue = 1; loadRdAddress = 9; loadFunct3 = 3'b010;
      step(); loadIssue = 0;
      #1;
      tests++; if (stall_i !== 1'b1) begin fails++; $display("FAIL stall_wait: got %b want 1", stall_i); end
      step();
      memRvalid = 1; memRdata = 32'h0000_1234;
      #1;
      tests++; if (stall_i !== 1'b1) begin fails++; $display("FAIL stall_rvalid_cycle: got %b want 1", stall_i); end
      step(); memRvalid = 0;
      #1;
      tests++; if (stall_i !== 1'b0) begin fails++; $display("FAIL stall_release: got %b want 0", stall_i); end
      tests++; if (we_i !== 1'b1 || rdAddress_i !== 5'd9) begin fails++; $display("FAIL stall_write: got we=%b addr=%0d want we=1 addr=9", we_i, rdAddress_i); end
      // Pending x0 never stalls and its write is dropped.
      rs1Address = 0; rs2Address = 0;
      loadIssue = 1; loadRdAddress = 0;
      step(); loadIssue = 0;
      #1;
      tests++; if (loadReady_i !== 1'b0 || stall_i !== 1'b0)
         begin fails++; $display("FAIL stall_x0: got loadReady=%b stall=%b want 0/0", loadReady_i, stall_i); end
      memRvalid = 1;
      step(); memRvalid = 0;
      tests++; if (we_i !== 1'b0) begin fails++; $display("FAIL load_x0_write: got we=%b want 0", we_i); end
      // RV32E compares only the low four address bits.
      rs1Address = 25;
      loadIssue = 1; loadRdAddress = 9;
      step(); loadIssue = 0;
      #1;
      tests++; if (stall_e !== 1'b1 || stall_i !== 1'b0)
         begin fails++; $display("FAIL stall_mask: got e=%b i=%b want e=1 i=0", stall_e, stall_i); end
      memRvalid = 1;
      step(); memRvalid = 0; rs1Address = 0;
   endtask

   task automatic test_x0_rv32e();
      aluValid = 1; aluRdAddress = 0; aluResult = 32'h0000DEAD;
      step(); aluValid = 0;
      tests++; if (we_i !== 1'b0 || we_e !== 1'b0 || illegal_e !== 1'b0)
         begin fails++; $display("FAIL x0_write: got we=%b/%b illegal=%b want 0/0/0", we_i, we_e, illegal_e); end
      step();
      aluValid = 1; aluRdAddress = 20; aluResult = 32'h000055AA;
      step(); aluValid = 0;
      tests++; if (we_i !== 1'b1 || rdAddress_i !== 5'd20 || illegal_i !== 1'b0)
         begin fails++; $display("FAIL x20_rv32i: got we=%b addr=%0d illegal=%b want 1/20/0", we_i, rdAddress_i, illegal_i); end
      tests++; if (we_e !== 1'b0 || illegal_e !== 1'b1)
         begin fails++; $display("FAIL x20_rv32e: got we=%b illegal=%b want 0/1", we_e, illegal_e); end
      tests++; if (rdAddress_e[4] !== 1'b0) begin fails++; $display("FAIL rv32e_addr_bit4: got %b want 0", rdAddress_e[4]); end
      step();
      tests++; if (illegal_e !== 1'b0) begin fails++; $display("FAIL illegal_pulse: got %b want 0", illegal_e); end
   endtask

   task automatic test_reset_mid_load();
      loadIssue = 1; loadRdAddress = 11; loadFunct3 = 3'b010;
      step(); loadIssue = 0;
      #1;
      tests++; if (loadReady_i !== 1'b0) begin fails++; $display("FAIL midload_busy: got %b want 0", loadReady_i); end
      reset = 1'b1;
      #2;
      tests++; if (loadReady_i !== 1'b1 || rd_i !== 32'd0 || rdAddress_i !== 5'd0 || we_i !== 1'b0)
         begin fails++; $display("FAIL midload_async: got ready=%b rd=%h addr=%0d we=%b want 1/0/0/0", loadReady_i, rd_i, rdAddress_i, we_i); end
      reset = 1'b0;
      memRvalid = 1; memRdata = 32'h7777_7777;
      step(); memRvalid = 0;
      tests++; if (we_i !== 1'b0 || rd_i !== 32'd0 || loadReady_i !== 1'b1)
         begin fails++; $display("FAIL midload_ignored: got we=%b rd=%h ready=%b want 0/0/1", we_i, rd_i, loadReady_i); end
   endtask

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   // Randomized traffic: writes form an in-order queue, one retired per cycle.
   task automatic test_random();
      wr_t         q[$];
      wr_t         w;
      bit          m_wait = 0;
      logic [4:0]  m_rd = 0;
      logic [2:0]  m_f3 = 0;
      logic [1:0]  m_off = 0;
      bit          alu_hold = 0;
      bit          exp_ar, ld_done, acc, has;
      logic [4:0]  pm;
      bit          exp_si, exp_se;
      idle_inputs();
      reset = 1'b1; step(); reset = 1'b0; step();
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!alu_hold) begin
            aluValid = ($urandom_range(0, 1) == 1);
            aluResult = $urandom;
            aluRdAddress = 5'($urandom_range(0, 31));
         end
         loadIssue = ($urandom_range(0, 3) == 0);
         loadRdAddress = 5'($urandom_range(0, 31));
         loadFunct3 = 3'($urandom_range(0, 7));
         loadByteOffset = 2'($urandom_range(0, 3));
         memRvalid = ($urandom_range(0, 2) == 0);
         memRdata = $urandom;
         rs1Address = ($urandom_range(0, 1) == 1) ? m_rd : 5'($urandom_range(0, 31));
         rs2Address = 5'($urandom_range(0, 31));
         #1;
         exp_ar = (q.size() == 0);
         exp_si = m_wait && (m_rd != 0) && (rs1Address == m_rd || rs2Address == m_rd);
         pm = m_rd & 5'h0F;
         exp_se = m_wait && (pm != 0) && ((rs1Address & 5'h0F) == pm || (rs2Address & 5'h0F) == pm);
         tests++; if (aluReady_i !== exp_ar || aluReady_e !== exp_ar)
            begin fails++; $display("FAIL rnd_aluReady c%0d: got %b/%b want %b", cyc, aluReady_i, aluReady_e, exp_ar); end
         tests++; if (loadReady_i !== !m_wait || loadReady_e !== !m_wait)
            begin fails++; $display("FAIL rnd_loadReady c%0d: got %b/%b want %b", cyc, loadReady_i, loadReady_e, !m_wait); end
         tests++; if (stall_i !== exp_si || stall_e !== exp_se)
            begin fails++; $display("FAIL rnd_stall c%0d: got %b/%b want %b/%b", cyc, stall_i, stall_e, exp_si, exp_se); end
         ld_done = m_wait && memRvalid;
         acc = aluValid && exp_ar;
         if (ld_done) q.push_back('{a: m_rd, d: m_ext(memRdata, m_f3, m_off)});
         if (!m_wait && loadIssue) begin
            m_wait = 1; m_rd = loadRdAddress; m_f3 = loadFunct3; m_off = loadByteOffset;
         end else if (ld_done) begin
            m_wait = 0;
         end
         if (acc) q.push_back('{a: aluRdAddress, d: aluResult});
         has = (q.size() > 0);
         w = '{a: 5'd0, d: 32'd0};
         if (has) w = q.pop_front();
         alu_hold = aluValid && !acc;
         step();
         tests++; if (we_i !== (has && w.a != 0) || illegal_i !== 1'b0)
            begin fails++; $display("FAIL rnd_we_i c%0d: got we=%b ill=%b want we=%b ill=0", cyc, we_i, illegal_i, has && w.a != 0); end
         tests++; if (we_e !== (has && w.a != 0 && !w.a[4]) || illegal_e !== (has && w.a[4]))
            begin fails++; $display("FAIL rnd_we_e c%0d: got we=%b ill=%b want we=%b ill=%b", cyc, we_e, illegal_e, has && w.a != 0 && !w.a[4], has && w.a[4]); end
         if (has) begin
            tests++; if (rd_i !== w.d || rdAddress_i !== w.a || rd_e !== w.d || rdAddress_e !== (w.a & 5'h0F))
               begin fails++; $display("FAIL rnd_data c%0d: got %h@%0d / %h@%0d want %h@%0d", cyc, rd_i, rdAddress_i, rd_e, rdAddress_e, w.d, w.a); end
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_load_extension();
      test_collision();
      test_load_use();
      test_x0_rv32e();
      test_reset_mid_load();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
